// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
interface bcd_serial_subtractor_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   diff;
   logic                  bout;
   logic                  invalid;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, invalid
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, invalid
   );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B - bin, one digit per clock, LSD first.
// Optional non-BCD digit detection enabled by BCD_SUB_INVALID_CHECK_EN.
module bcd_serial_subtractor #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bcd_serial_subtractor_if.slave  bus
);
   localparam int unsigned W = 4 * DIGITS;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [W-1:0]   res_q, res_d, diff_q, diff_d;
   logic           brw_q, brw_d, bout_q, bout_d;
   logic [4:0]     idx_q, idx_d;
   logic [4:0]     sub;
   logic [3:0]     dig;
   logic           brw_new;
`ifdef BCD_SUB_INVALID_CHECK_EN
   logic           inv_q, inv_d, invalid_q, invalid_d;
`endif

   // Operand registers shift right so the current digit is always at [3:0].
   always_comb begin
      sub     = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, brw_q};
      brw_new = sub[4];
      dig     = sub[4] ? (sub[3:0] + 4'd10) : sub[3:0];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      idx_d   = idx_q;
`ifdef BCD_SUB_INVALID_CHECK_EN
      inv_d     = inv_q;
      invalid_d = invalid_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               brw_d   = bus.bin;
               idx_d   = '0;
               res_d   = '0;
`ifdef BCD_SUB_INVALID_CHECK_EN
               inv_d   = 1'b0;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 4;
            b_d   = b_q >> 4;
            res_d = (res_q >> 4) | (W'(dig) << (W - 4));
            brw_d = brw_new;
            idx_d = idx_q + 5'd1;
`ifdef BCD_SUB_INVALID_CHECK_EN
            inv_d = inv_q | (a_q[3:0] > 4'd9) | (b_q[3:0] > 4'd9);
`endif
            if (idx_q == 5'(DIGITS - 1)) begin
               state_d = StDone;
               diff_d  = res_d;
               bout_d  = brw_new;
`ifdef BCD_SUB_INVALID_CHECK_EN
               invalid_d = inv_d;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef BCD_SUB_INVALID_CHECK_EN
         inv_q     <= 1'b0;
         invalid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         idx_q   <= idx_d;
`ifdef BCD_SUB_INVALID_CHECK_EN
         inv_q     <= inv_d;
         invalid_q <= invalid_d;
`endif
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = (state_q == StDone);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef BCD_SUB_INVALID_CHECK_EN
   assign bus.invalid = invalid_q;
`else
   assign bus.invalid = 1'b0;
`endif
endmodule
